// File: rtl/troco_if.sv
// troco_if: handshake bundle between vending core/coin ejector and the change dispenser
interface troco_if;
  logic       dar_troco;
  logic [7:0] valor_troco;
  logic       coin_ack;
  logic       recarga;
  logic       moeda_req;
  logic [2:0] moeda_tipo;
  logic       ocupado;
  logic       concluido;
  logic       falta_troco;
  logic [7:0] troco_restante;
  modport master (
    output dar_troco, valor_troco, coin_ack, recarga,
    input  moeda_req, moeda_tipo, ocupado, concluido, falta_troco, troco_restante
  );
  modport slave (
    input  dar_troco, valor_troco, coin_ack, recarga,
    output moeda_req, moeda_tipo, ocupado, concluido, falta_troco, troco_restante
  );
endinterface

// File: rtl/troco_dispenser.sv
// troco_dispenser: greedy change sequencer issuing one coin at a time over req/ack with stock tracking
module troco_dispenser #(
  parameter int ESTOQUE_W   = 4,
  parameter int ESTOQUE_INI = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic   clock,
  input  logic   reset_n,
  troco_if.slave bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [ESTOQUE_W-1:0] INI = ESTOQUE_W'(ESTOQUE_INI);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {OCIOSO, SELECIONA, PEDE, FIM, ERRO} estado_t;
  estado_t state_q, state_d;
  logic [7:0] rest_q, rest_d;
  logic [2:0] tipo_q, tipo_d, sel;
  logic req_q, req_d, sel_ok;
  logic ocupado_q, concluido_q, falta_q;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [ESTOQUE_W-1:0] estoque_q [5];
  logic [ESTOQUE_W-1:0] estoque_d [5];
  function automatic logic [7:0] valor(input logic [2:0] c);
    return c == 3'd0 ? 8'd1 : c == 3'd1 ? 8'd5 : c == 3'd2 ? 8'd10 : c == 3'd3 ? 8'd25 : 8'd50;
  endfunction
  // ascending scan: the last hit is the largest payable denomination in stock
  always_comb begin
    sel_ok = 1'b0;
    sel = 3'd0;
    for (int i = 0; i < 5; i++)
      if (estoque_q[i] != '0 && valor(3'(i)) <= rest_q) begin
        sel_ok = 1'b1;
        sel = 3'(i);
      end
  end
  always_comb begin
    state_d = state_q;
    rest_d = rest_q;
    tipo_d = tipo_q;
    req_d = req_q;
    tmo_d = tmo_q;
    estoque_d = estoque_q;
    case (state_q)
      OCIOSO: begin
        if (bus.recarga) for (int i = 0; i < 5; i++) estoque_d[i] = INI;
        if (bus.dar_troco) begin
          rest_d = bus.valor_troco;
          state_d = SELECIONA;
        end
      end
      SELECIONA: begin
        if (sel_ok) begin
          state_d = PEDE;
          tipo_d = sel;
          req_d = 1'b1;
          tmo_d = '0;
        end else state_d = rest_q == 8'd0 ? FIM : ERRO;
      end
      PEDE: begin
        if (bus.coin_ack) begin
          if (estoque_q[tipo_q] != '0) estoque_d[tipo_q] = estoque_q[tipo_q] - ESTOQUE_W'(1);
          rest_d = rest_q - valor(tipo_q);
          req_d = 1'b0;
          state_d = SELECIONA;
        end else if (tmo_q == TMAX) begin
          req_d = 1'b0;
          state_d = ERRO;
        end else tmo_d = tmo_q + TW'(1);
      end
      FIM: state_d = OCIOSO;
      ERRO: begin
        if (bus.recarga) begin
          for (int i = 0; i < 5; i++) estoque_d[i] = INI;
          rest_d = 8'd0;
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= OCIOSO;
      rest_q <= 8'd0;
      tipo_q <= 3'd0;
      req_q <= 1'b0;
      tmo_q <= '0;
      ocupado_q <= 1'b0;
      concluido_q <= 1'b0;
      falta_q <= 1'b0;
      for (int i = 0; i < 5; i++) estoque_q[i] <= INI;
    end else begin
      state_q <= state_d;
      rest_q <= rest_d;
      tipo_q <= tipo_d;
      req_q <= req_d;
      tmo_q <= tmo_d;
      ocupado_q <= state_d != OCIOSO;
      concluido_q <= state_d == FIM;
      falta_q <= state_d == ERRO;
      estoque_q <= estoque_d;
    end
  end
  assign bus.moeda_req = req_q;
  assign bus.moeda_tipo = tipo_q;
  assign bus.ocupado = ocupado_q;
  assign bus.concluido = concluido_q;
  assign bus.falta_troco = falta_q;
  assign bus.troco_restante = rest_q;
endmodule

// File: tb/tb_troco_dispenser.sv
// tb_troco_dispenser: scenario tasks with a greedy-model coin scoreboard; second instance has stock 2
module tb_troco_dispenser;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic dar = 1'b0, ack = 1'b0, recarga = 1'b0, sel = 1'b0;
  logic [7:0] valor = 8'd0;
  int total = 0, bad = 0;
  int vals [5] = '{1, 5, 10, 25, 50};
  int stk [5];
  int exp_rest;
  logic [2:0] q [$];
  troco_if b ();
  troco_if b2 ();
  troco_dispenser u1 (.clock(clock), .reset_n(reset_n), .bus(b.slave));
  troco_dispenser #(.ESTOQUE_INI(2)) u2 (.clock(clock), .reset_n(reset_n), .bus(b2.slave));
  assign b.dar_troco = dar & ~sel;
  assign b2.dar_troco = dar & sel;
  assign b.valor_troco = valor;
  assign b2.valor_troco = valor;
  assign b.coin_ack = ack & ~sel;
  assign b2.coin_ack = ack & sel;
  assign b.recarga = recarga & ~sel;
  assign b2.recarga = recarga & sel;
  logic o_req, o_ocup, o_concl, o_falta;
  logic [2:0] o_tipo;
  logic [7:0] o_rest;
  assign o_req = sel ? b2.moeda_req : b.moeda_req;
  assign o_tipo = sel ? b2.moeda_tipo : b.moeda_tipo;
  assign o_ocup = sel ? b2.ocupado : b.ocupado;
  assign o_concl = sel ? b2.concluido : b.concluido;
  assign o_falta = sel ? b2.falta_troco : b.falta_troco;
  assign o_rest = sel ? b2.troco_restante : b.troco_restante;
  always #5 clock = ~clock;
  function automatic int stock(input int i);
    return sel ? int'(u2.estoque_q[i]) : int'(u1.estoque_q[i]);
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    dar = 1'b0; ack = 1'b0; recarga = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) stk[i] = sel ? 2 : 8;
    q.delete();
  endtask
  task automatic give(input int v);
    int rem = v, mi;
    do begin
      mi = -1;
      for (int i = 0; i < 5; i++) if (vals[i] <= rem && stk[i] > 0) mi = i;
      if (mi >= 0) begin
        q.push_back(3'(mi));
        stk[mi]--;
        rem -= vals[mi];
      end
    end while (mi >= 0);
    exp_rest = rem;
    valor = 8'(v); dar = 1'b1;
    tick();
    dar = 1'b0;
  endtask
  task automatic serve(input bit doack, input bit poke, output int hi, output int coins);
    bit done = 0, prev = 0;
    logic [2:0] e;
    hi = 0; coins = 0;
    for (int n = 0; n < 80 && !done; n++) begin
      tick();
      ack = 1'b0;
      if (o_req) hi++;
      if (o_req && !prev) begin
        coins++;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL extra_coin: got tipo %0d, expected no request", o_tipo);
        end else begin
          e = q.pop_front();
          if (o_tipo !== e) begin
            bad++;
            $display("FAIL coin_tipo: got %0d expected %0d", o_tipo, e);
          end
        end
        ack = doack;
        if (poke) begin
          dar = coins == 1; valor = 8'd99; recarga = coins == 1;
        end
      end
      if (o_concl || o_falta) done = 1;
      prev = o_req;
    end
    ack = 1'b0; dar = 1'b0; recarga = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL serve_budget: no concluido/falta_troco within 80 cycles, expected one");
    end
  endtask
  task automatic check_end(input string nm);
    total += 7;
    if (q.size() != 0) begin bad++; $display("FAIL %s_missing: %0d coins not requested, expected 0", nm, q.size()); end
    if (o_rest !== 8'(exp_rest)) begin bad++; $display("FAIL %s_rest: got %0d expected %0d", nm, o_rest, exp_rest); end
    for (int i = 0; i < 5; i++)
      if (stock(i) != stk[i]) begin bad++; $display("FAIL %s_stock%0d: got %0d expected %0d", nm, i, stock(i), stk[i]); end
  endtask
  task automatic test_reset();
    sel = 1'b0;
    do_reset();
    total++;
    if ({o_req, o_tipo, o_ocup, o_concl, o_falta, o_rest} !== 15'd0) begin
      bad++; $display("FAIL reset_outputs: got %h expected 0", {o_req, o_tipo, o_ocup, o_concl, o_falta, o_rest});
    end
    check_end("reset");
  endtask
  task automatic test_greedy();
    int hi, coins;
    sel = 1'b0;
    do_reset();
    give(68);
    serve(1'b1, 1'b0, hi, coins);
    total += 2;
    if (coins != 6) begin bad++; $display("FAIL greedy_coins: got %0d expected 6", coins); end
    if (o_concl !== 1'b1) begin bad++; $display("FAIL greedy_concl: got %b expected 1", o_concl); end
    check_end("greedy");
    tick();
    total++;
    if ({o_concl, o_ocup} !== 2'b00) begin bad++; $display("FAIL greedy_after: concl/ocup got %b expected 00", {o_concl, o_ocup}); end
  endtask
  task automatic test_zero();
    bit sawreq = 0;
    sel = 1'b0;
    do_reset();
    valor = 8'd0; dar = 1'b1;
    tick();
    dar = 1'b0;
    sawreq |= o_req;
    total++;
    if ({o_ocup, o_concl} !== 2'b10) begin bad++; $display("FAIL zero_c1: ocup/concl got %b expected 10", {o_ocup, o_concl}); end
    tick();
    sawreq |= o_req;
    total++;
    if ({o_ocup, o_concl} !== 2'b11) begin bad++; $display("FAIL zero_c2: ocup/concl got %b expected 11", {o_ocup, o_concl}); end
    tick();
    sawreq |= o_req;
    total += 2;
    if ({o_ocup, o_concl} !== 2'b00) begin bad++; $display("FAIL zero_c3: ocup/concl got %b expected 00", {o_ocup, o_concl}); end
    if (sawreq) begin bad++; $display("FAIL zero_req: moeda_req got 1 expected 0"); end
  endtask
  task automatic test_shortfall();
    int hi, coins;
    sel = 1'b1;
    do_reset();
    give(9);
    serve(1'b1, 1'b0, hi, coins);
    total += 2;
    if (coins != 3) begin bad++; $display("FAIL short_coins: got %0d expected 3", coins); end
    if (o_falta !== 1'b1) begin bad++; $display("FAIL short_falta: got %b expected 1", o_falta); end
    check_end("short");
    recarga = 1'b1;
    tick();
    recarga = 1'b0;
    for (int i = 0; i < 5; i++) stk[i] = 2;
    exp_rest = 0;
    total++;
    if ({o_falta, o_ocup} !== 2'b00) begin bad++; $display("FAIL short_clear: falta/ocup got %b expected 00", {o_falta, o_ocup}); end
    check_end("short_refill");
    sel = 1'b0;
  endtask
  task automatic test_timeout();
    int hi, coins;
    sel = 1'b0;
    do_reset();
    give(25);
    stk[3] = 8;
    exp_rest = 25;
    serve(1'b0, 1'b0, hi, coins);
    total += 3;
    if (hi != 16) begin bad++; $display("FAIL tmo_cycles: req high %0d cycles expected 16", hi); end
    if (o_falta !== 1'b1) begin bad++; $display("FAIL tmo_falta: got %b expected 1", o_falta); end
    if (o_req !== 1'b0) begin bad++; $display("FAIL tmo_req: got %b expected 0", o_req); end
    check_end("tmo");
  endtask
  task automatic test_busy();
    int hi, coins;
    sel = 1'b0;
    do_reset();
    give(30);
    serve(1'b1, 1'b1, hi, coins);
    total++;
    if (coins != 2) begin bad++; $display("FAIL busy_coins: got %0d expected 2", coins); end
    check_end("busy");
    tick();
    total++;
    if (o_ocup !== 1'b0) begin bad++; $display("FAIL busy_relatch: ocupado got %b expected 0", o_ocup); end
  endtask
  task automatic test_reset_mid();
    int n = 0;
    sel = 1'b0;
    do_reset();
    give(68);
    while (!o_req && n < 10) begin tick(); n++; end
    total++;
    if ({o_req, o_tipo} !== 4'b1100) begin bad++; $display("FAIL mid_pre: req/tipo got %b expected 1100", {o_req, o_tipo}); end
    reset_n = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) stk[i] = 8;
    exp_rest = 0;
    q.delete();
    total++;
    if ({o_req, o_ocup} !== 2'b00) begin bad++; $display("FAIL mid_post: req/ocup got %b expected 00", {o_req, o_ocup}); end
    check_end("mid");
    reset_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_greedy();
    test_zero();
    test_shortfall();
    test_timeout();
    test_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
